// File: rtl/flexcounter_pkg.sv
// flexcounter_pkg -- shared constants for the programmable wrap counter.
//   COUNTSIZE_DEFAULT  : default upper bound on the terminal count
//   count_width()      : width of every count bus for a given COUNTSIZE
//   COUNTWIDTH_DEFAULT : count_width(COUNTSIZE_DEFAULT), 14 bits
//   count_action_e     : per-cycle action chosen by the next-state logic
package flexcounter_pkg;

  localparam int unsigned COUNTSIZE_DEFAULT = 10000;

  // A bound below 2 would give a zero-width bus; keep at least one bit.
  function automatic int unsigned count_width(input int unsigned size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

  localparam int unsigned COUNTWIDTH_DEFAULT = count_width(COUNTSIZE_DEFAULT);

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_INC  = 2'd1,
    ACT_WRAP = 2'd2
  } count_action_e;

endpackage

// File: rtl/flexcounter_if.sv
// flexcounter_if -- signal bundle for flex_counter.
//   clk           : sole clock
//   nRST          : synchronous reset, active-high despite the name
//   enableCounter : 1 = advance each edge, 0 = hold
//   maxCount      : terminal count, unsigned, COUNTWIDTH bits
//   count         : current counter value, COUNTWIDTH bits
//   strobe        : one-cycle wrap pulse
// Modports: dut (design side) and tb (mirror).
interface flexcounter_if #(
  parameter int unsigned COUNTSIZE = flexcounter_pkg::COUNTSIZE_DEFAULT
) ();
  import flexcounter_pkg::*;

  localparam int unsigned COUNTWIDTH = count_width(COUNTSIZE);

  logic                  clk;
  logic                  nRST;
  logic                  enableCounter;
  logic [COUNTWIDTH-1:0] maxCount;
  logic [COUNTWIDTH-1:0] count;
  logic                  strobe;

  modport dut (
    input  clk,
    input  nRST,
    input  enableCounter,
    input  maxCount,
    output count,
    output strobe
  );

  modport tb (
    output clk,
    output nRST,
    output enableCounter,
    output maxCount,
    input  count,
    input  strobe
  );

endinterface

// File: rtl/flex_counter.sv
// flex_counter -- programmable up-counter that wraps to 0 after reaching
// maxCount and pulses strobe for the cycle in which count reads 0 after a wrap.
// Port: bus (flexcounter_if.dut)
//   in : clk, nRST (sync, active-high), enableCounter, maxCount
//   out: count (registered), strobe (registered)
// COUNTSIZE must match the parameter of the connected interface instance.
module flex_counter
  import flexcounter_pkg::*;
#(
  parameter int unsigned COUNTSIZE = COUNTSIZE_DEFAULT
) (
  flexcounter_if.dut bus
);

  localparam int unsigned COUNTWIDTH = count_width(COUNTSIZE);

  logic [COUNTWIDTH-1:0] r_count;
  logic                  r_strobe;

  count_action_e         w_action;
  logic [COUNTWIDTH-1:0] w_next_count;
  logic                  w_next_strobe;

  // Wrapping on >= (not ==) means a maxCount lowered below the current
  // value still wraps on the next enabled edge instead of running on.
  always_comb begin
    w_action      = ACT_HOLD;
    w_next_count  = r_count;
    w_next_strobe = 1'b0;

    if (bus.enableCounter) begin
      w_action = (r_count >= bus.maxCount) ? ACT_WRAP : ACT_INC;
    end

    unique case (w_action)
      ACT_INC:  w_next_count = r_count + COUNTWIDTH'(1);
      ACT_WRAP: begin
        w_next_count  = '0;
        w_next_strobe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge bus.clk) begin
    if (bus.nRST) begin
      r_count  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_count  <= w_next_count;
      r_strobe <= w_next_strobe;
    end
  end

  assign bus.count  = r_count;
  assign bus.strobe = r_strobe;

endmodule

// File: tb/tb_flex_counter.sv
module tb_flex_counter;
  import flexcounter_pkg::*;

  flexcounter_if #(.COUNTSIZE(COUNTSIZE_DEFAULT)) tbif ();

  flex_counter #(.COUNTSIZE(COUNTSIZE_DEFAULT)) dut (
    .bus (tbif)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial tbif.clk = 1'b0;
  always #5 tbif.clk = ~tbif.clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge tbif.clk);
    #1;
  endtask

  task automatic do_reset();
    tbif.nRST = 1'b1;
    tbif.enableCounter = 1'b0;
    tick();
    tbif.nRST = 1'b0;
  endtask

  task automatic test_reset();
    tbif.nRST = 1'b1;
    tbif.enableCounter = 1'b0;
    tbif.maxCount = '0;
    tick();
    @(negedge tbif.clk);
    tbif.nRST = 1'b0;
    n_checks++;
    if (tbif.count !== 14'd0 || tbif.strobe !== 1'b0) begin
      $display("FAIL reset_state: count=%0d strobe=%0b, required count=0 strobe=0", tbif.count, tbif.strobe);
      n_errors++;
    end
    // Reset must win over enable.
    tbif.nRST = 1'b1;
    tbif.enableCounter = 1'b1;
    tbif.maxCount = 14'd3;
    tick();
    tick();
    n_checks++;
    if (tbif.count !== 14'd0 || tbif.strobe !== 1'b0) begin
      $display("FAIL reset_priority: count=%0d strobe=%0b, required count=0 strobe=0", tbif.count, tbif.strobe);
      n_errors++;
    end
    tbif.nRST = 1'b0;
    tbif.enableCounter = 1'b0;
  endtask

  task automatic test_wrap3();
    int exp_c [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    logic exp_s [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    do_reset();
    tbif.maxCount = 14'd3;
    tbif.enableCounter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (tbif.count !== exp_c[i] || tbif.strobe !== exp_s[i]) begin
        $display("FAIL wrap3[%0d]: count=%0d strobe=%0b, required count=%0d strobe=%0b",
                 i, tbif.count, tbif.strobe, exp_c[i], exp_s[i]);
        n_errors++;
      end
    end
  endtask

  task automatic test_enable_hold();
    int exp_c [4] = '{3, 4, 5, 0};
    logic exp_s [4] = '{0, 0, 0, 1};
    do_reset();
    tbif.maxCount = 14'd5;
    tbif.enableCounter = 1'b1;
    tick();
    tick();
    n_checks++;
    if (tbif.count !== 14'd2) begin
      $display("FAIL hold_pre: count=%0d, required 2", tbif.count);
      n_errors++;
    end
    tbif.enableCounter = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (tbif.count !== 14'd2 || tbif.strobe !== 1'b0) begin
        $display("FAIL hold[%0d]: count=%0d strobe=%0b, required count=2 strobe=0", i, tbif.count, tbif.strobe);
        n_errors++;
      end
    end
    tbif.enableCounter = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (tbif.count !== exp_c[i] || tbif.strobe !== exp_s[i]) begin
        $display("FAIL hold_resume[%0d]: count=%0d strobe=%0b, required count=%0d strobe=%0b",
                 i, tbif.count, tbif.strobe, exp_c[i], exp_s[i]);
        n_errors++;
      end
    end
  endtask

  task automatic test_max_change();
    do_reset();
    tbif.maxCount = 14'd10;
    tbif.enableCounter = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (tbif.count !== 14'd7 || tbif.strobe !== 1'b0) begin
      $display("FAIL maxchg_pre: count=%0d strobe=%0b, required count=7 strobe=0", tbif.count, tbif.strobe);
      n_errors++;
    end
    tbif.maxCount = 14'd4;
    tick();
    n_checks++;
    if (tbif.count !== 14'd0 || tbif.strobe !== 1'b1) begin
      $display("FAIL maxchg_wrap: count=%0d strobe=%0b, required count=0 strobe=1", tbif.count, tbif.strobe);
      n_errors++;
    end
    tick();
    n_checks++;
    if (tbif.count !== 14'd1 || tbif.strobe !== 1'b0) begin
      $display("FAIL maxchg_after: count=%0d strobe=%0b, required count=1 strobe=0", tbif.count, tbif.strobe);
      n_errors++;
    end
  endtask

  task automatic test_max_zero();
    do_reset();
    tbif.maxCount = 14'd0;
    tbif.enableCounter = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (tbif.count !== 14'd0 || tbif.strobe !== 1'b1) begin
        $display("FAIL max0[%0d]: count=%0d strobe=%0b, required count=0 strobe=1", i, tbif.count, tbif.strobe);
        n_errors++;
      end
    end
    tbif.enableCounter = 1'b0;
    tick();
    n_checks++;
    if (tbif.count !== 14'd0 || tbif.strobe !== 1'b0) begin
      $display("FAIL max0_disable: count=%0d strobe=%0b, required count=0 strobe=0", tbif.count, tbif.strobe);
      n_errors++;
    end
  endtask

  task automatic test_max_big();
    int cycles;
    int prev;
    bit seen;
    do_reset();
    tbif.maxCount = 14'd9999;
    tbif.enableCounter = 1'b1;
    cycles = 0;
    prev = 0;
    seen = 1'b0;
    while (!seen && cycles < 20000) begin
      prev = int'(tbif.count);
      tick();
      cycles++;
      if (tbif.strobe === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cycles != 10000) begin
      $display("FAIL max9999_period: strobe seen=%0b after %0d cycles, required 10000", seen, cycles);
      n_errors++;
    end
    n_checks++;
    if (prev != 9999 || tbif.count !== 14'd0) begin
      $display("FAIL max9999_wrap: prev=%0d count=%0d, required prev=9999 count=0", prev, tbif.count);
      n_errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tbif.maxCount = 14'd10;
    tbif.enableCounter = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (tbif.count !== 14'd6) begin
      $display("FAIL rstmid_pre: count=%0d, required 6", tbif.count);
      n_errors++;
    end
    tbif.nRST = 1'b1;
    tick();
    n_checks++;
    if (tbif.count !== 14'd0 || tbif.strobe !== 1'b0) begin
      $display("FAIL rstmid_reset: count=%0d strobe=%0b, required count=0 strobe=0", tbif.count, tbif.strobe);
      n_errors++;
    end
    tbif.nRST = 1'b0;
    tick();
    n_checks++;
    if (tbif.count !== 14'd1 || tbif.strobe !== 1'b0) begin
      $display("FAIL rstmid_restart: count=%0d strobe=%0b, required count=1 strobe=0", tbif.count, tbif.strobe);
      n_errors++;
    end
  endtask

  initial begin
    tbif.nRST = 1'b1;
    tbif.enableCounter = 1'b0;
    tbif.maxCount = '0;
    test_reset();
    test_wrap3();
    test_enable_hold();
    test_max_change();
    test_max_zero();
    test_max_big();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
